hit_packet_rx: RTL and testbench
================================

# hit_packet_rx

Receives the byte stream from the IR link's UART receiver and assembles framed hit-position packets. Each packet is checked for sync, checksum, screen range and repeated transmission. Each accepted packet becomes a one-cycle `trigger` pulse with stable `x`/`y` coordinates. Sits directly upstream of the shot-blob display stage and drives that stage's `trigger`, `x` and `y` inputs.

## Interface

Parameters:
- `TIMEOUT`, 640_000: maximum cycles allowed between bytes of one packet (10 ms at 64 MHz).
- `DUP_WINDOW`, 32_500_000: cycles after an accepted hit during which an identical coordinate is discarded.
- `H_ACTIVE`, 1024: x must be strictly less than this.
- `V_ACTIVE`, 768: y must be strictly less than this.

Ports:
- `clk`, in, 1: single clock domain; all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `rx_valid`, in, 1: one-cycle strobe; `rx_byte` is valid on that cycle.
- `rx_byte`, in, 8: received byte.
- `trigger`, out, 1: one-cycle pulse per accepted hit.
- `x`, out, 11: hit x; held until the next accepted hit.
- `y`, out, 10: hit y; held until the next accepted hit.
- `pkt_err`, out, 1: one-cycle pulse per rejected packet.
- `err_count`, out, 8: saturating count of rejected packets.

## Operation

- Packet is 6 bytes, in order: SYNC=0xA5, XH={5'b0,x[10:8]}, XL=x[7:0], YH={6'b0,y[9:8]}, YL=y[7:0], CHK.
- CHK is the XOR of XH, XL, YH and YL.
- FSM states: HUNT, XH, XL, YH, YL, CHK. Each state advances on `rx_valid`.
- HUNT: a byte of 0xA5 moves to XH; any other byte is ignored silently (no error).
- Inside a packet, 0xA5 is treated as data. There is no mid-packet resync.
- XH with bits [7:3] nonzero, or YH with bits [7:2] nonzero, is an error. Go to HUNT.
- In state CHK, the received byte is compared with the running XOR.
  - Mismatch is an error.
  - x ≥ H_ACTIVE or y ≥ V_ACTIVE is an error.
  - Otherwise the candidate is a valid hit.
- The FSM returns to HUNT after the CHK byte regardless of outcome.
- Duplicate filter: a valid hit is dropped if its {x,y} equals the last accepted {x,y} and the dup timer is below DUP_WINDOW.
  - A dropped duplicate is not an error and does not restart the timer.
- Accepted hit effects:
  - `x`/`y` are loaded.
  - `trigger` pulses.
  - The dup timer clears to 0. It counts up every cycle and saturates at DUP_WINDOW.
- After reset the dup timer starts saturated, so the first valid hit is always accepted.
- Gap timer:
  - Clears on every `rx_valid`.
  - Counts only while not in HUNT.
  - Reaching TIMEOUT is an error and the FSM goes to HUNT.
- Error effects: `pkt_err` pulses one cycle; `err_count` increments and saturates at 255.
- Timeout and `rx_valid` on the same cycle: the timeout wins and the byte is discarded. It is not re-examined as SYNC.

## Timing

- Reset values: `trigger`=0, `x`=0, `y`=0, `pkt_err`=0, `err_count`=0, FSM=HUNT, gap timer=0, dup timer=DUP_WINDOW.
- Latency: `trigger`, `x` and `y` update on the cycle after the CHK `rx_valid`. All outputs are registered.
- `x`/`y` change only on the same cycle `trigger` is high.
- `pkt_err` follows the same one-cycle latency from the offending byte or timeout cycle.
- Minimum trigger spacing is 6 `rx_valid` events. `trigger` is never high on two consecutive cycles, so the downstream rising-edge detector sees every pulse.
- Back-to-back `rx_valid` every cycle is supported with no stalls.
- Reset asserted mid-packet: immediate return to the reset values, and the partial packet is lost.

## Structure

- Shared package holds:
  - SYNC byte constant 0xA5.
  - Packet length 6.
  - FSM state enum.
  - Coordinate widths: 11 for x, 10 for y.
- Counter widths are derived from TIMEOUT and DUP_WINDOW via $clog2.
- One natural sub-module: `rx_gap_timer`. It is a clearable, saturating counter with a `hit` flag, instantiated twice: once for the gap timer and once for the dup timer.

## Test plan

- Send A5 01 2C 00 C8 E5 → one `trigger` cycle after the last byte; `x`=300, `y`=200; `pkt_err` stays 0.
- Same 6 bytes again 1000 cycles later → no `trigger` and no error. Same bytes after DUP_WINDOW+10 cycles → `trigger` with `x`=300, `y`=200.
- A5 01 2C 00 C8 E4 (bad CHK) → `pkt_err` pulse; `err_count`=1; `x`/`y` unchanged.
- A5 04 00 00 00 04 (x=1024) → rejected, `err_count` increments. A5 03 FF 02 FF 01 (x=1023, y=767) → accepted.
- A5 01 2C, then silence for TIMEOUT cycles → `pkt_err` pulse and FSM back in HUNT. A following full valid packet is accepted.
- Drive 300 bad packets → `err_count` saturates at 255. Assert `reset_n` low mid-packet → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/hit_packet_rx_pkg.sv
// Shared constants and types for the IR hit-packet receiver.
// Framing bytes, coordinate widths and the packet-assembly state encoding live here.
package hit_packet_rx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         PKT_LEN   = 6;
    localparam int         X_W       = 11;
    localparam int         Y_W       = 10;

    // One state per byte position in the packet.
    typedef enum logic [$clog2(PKT_LEN)-1:0] {
        ST_HUNT,
        ST_XH,
        ST_XL,
        ST_YH,
        ST_YL,
        ST_CHK
    } state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// Clearable up-counter that saturates at LIMIT and flags when it is there.
// START_SAT selects whether reset leaves it at zero or already saturated.
module rx_gap_timer #(
    parameter int LIMIT     = 16,
    parameter bit START_SAT = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int            W       = $clog2(LIMIT + 1);
    localparam logic [W-1:0]  LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= START_SAT ? LIMIT_V : '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT_V)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign hit = (count_reg == LIMIT_V);

endmodule

// File: rtl/hit_packet_rx.sv
// Assembles 6-byte IR hit packets, validates sync/checksum/range/repeats and
// emits a one-cycle trigger with held x/y, or a pkt_err pulse with a saturating count.
module hit_packet_rx
    import hit_packet_rx_pkg::*;
#(
    parameter int TIMEOUT    = 640_000,
    parameter int DUP_WINDOW = 32_500_000,
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           rx_valid,
    input  logic [7:0]     rx_byte,
    output logic           trigger,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pkt_err,
    output logic [7:0]     err_count
);

    localparam logic [X_W:0] H_LIM = (X_W + 1)'(H_ACTIVE);
    localparam logic [Y_W:0] V_LIM = (Y_W + 1)'(V_ACTIVE);

    state_t         state_reg, state_next;
    logic [2:0]     x_hi_reg;
    logic [7:0]     x_lo_reg;
    logic [1:0]     y_hi_reg;
    logic [7:0]     y_lo_reg;
    logic [7:0]     chk_reg;

    logic           gap_hit, dup_hit;
    logic           timeout, byte_ok;
    logic           accept, reject;
    logic           is_dup;
    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] cand_y;

    assign cand_x  = {x_hi_reg, x_lo_reg};
    assign cand_y  = {y_hi_reg, y_lo_reg};
    assign timeout = gap_hit && (state_reg != ST_HUNT);
    // A byte arriving on the timeout cycle is dropped, never reconsidered as SYNC.
    assign byte_ok = rx_valid && !timeout;
    assign is_dup  = !dup_hit && (cand_x == x) && (cand_y == y);

    rx_gap_timer #(
        .LIMIT     (TIMEOUT),
        .START_SAT (1'b0)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (rx_valid || (state_reg == ST_HUNT)),
        .enable  (state_reg != ST_HUNT),
        .hit     (gap_hit)
    );

    // Starts saturated so the very first valid hit can never be a duplicate.
    rx_gap_timer #(
        .LIMIT     (DUP_WINDOW),
        .START_SAT (1'b1)
    ) u_dup_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (1'b1),
        .hit     (dup_hit)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        if (timeout) begin
            reject     = 1'b1;
            state_next = ST_HUNT;
        end else if (rx_valid) begin
            unique case (state_reg)
                ST_HUNT: begin
                    if (rx_byte == SYNC_BYTE) state_next = ST_XH;
                end
                ST_XH: begin
                    if (rx_byte[7:3] != 5'd0) begin
                        reject     = 1'b1;
                        state_next = ST_HUNT;
                    end else begin
                        state_next = ST_XL;
                    end
                end
                ST_XL: state_next = ST_YH;
                ST_YH: begin
                    if (rx_byte[7:2] != 6'd0) begin
                        reject     = 1'b1;
                        state_next = ST_HUNT;
                    end else begin
                        state_next = ST_YL;
                    end
                end
                ST_YL: state_next = ST_CHK;
                ST_CHK: begin
                    state_next = ST_HUNT;
                    if (rx_byte != chk_reg) begin
                        reject = 1'b1;
                    end else if (({1'b0, cand_x} >= H_LIM) || ({1'b0, cand_y} >= V_LIM)) begin
                        reject = 1'b1;
                    end else if (!is_dup) begin
                        accept = 1'b1;
                    end
                end
                default: state_next = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_HUNT;
            x_hi_reg  <= '0;
            x_lo_reg  <= '0;
            y_hi_reg  <= '0;
            y_lo_reg  <= '0;
            chk_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (byte_ok) begin
                unique case (state_reg)
                    ST_HUNT: chk_reg <= '0;
                    ST_XH: begin
                        x_hi_reg <= rx_byte[2:0];
                        chk_reg  <= chk_reg ^ rx_byte;
                    end
                    ST_XL: begin
                        x_lo_reg <= rx_byte;
                        chk_reg  <= chk_reg ^ rx_byte;
                    end
                    ST_YH: begin
                        y_hi_reg <= rx_byte[1:0];
                        chk_reg  <= chk_reg ^ rx_byte;
                    end
                    ST_YL: begin
                        y_lo_reg <= rx_byte;
                        chk_reg  <= chk_reg ^ rx_byte;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trigger   <= 1'b0;
            x         <= '0;
            y         <= '0;
            pkt_err   <= 1'b0;
            err_count <= '0;
        end else begin
            trigger <= accept;
            pkt_err <= reject;
            if (accept) begin
                x <= cand_x;
                y <= cand_y;
            end
            if (reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hit_packet_rx.sv
// Bench for hit_packet_rx: directed vector table, hand sequences for timeout,
// reset and saturation, then random packets scored against a packet-level model.
module tb_hit_packet_rx;

    localparam int TIMEOUT = 40;
    localparam int DUP     = 2000;
    localparam int H       = 1024;
    localparam int V       = 768;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        trigger;
    logic [10:0] x;
    logic [9:0]  y;
    logic        pkt_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    hit_packet_rx #(
        .TIMEOUT    (TIMEOUT),
        .DUP_WINDOW (DUP),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .trigger   (trigger),
        .x         (x),
        .y         (y),
        .pkt_err   (pkt_err),
        .err_count (err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int trig_seen = 0;
    int err_seen  = 0;
    int model_time = 0;

    // Expected state, kept at packet granularity.
    int          exp_trig = 0;
    int          exp_errp = 0;
    int          exp_errs = 0;
    logic [10:0] exp_x = '0;
    logic [9:0]  exp_y = '0;
    bit          have_acc = 1'b0;
    int          last_acc = 0;

    logic        prev_trig = 1'b0;
    logic [10:0] prev_x = '0;
    logic [9:0]  prev_y = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (trigger) begin
                trig_seen++;
                n_checks++;
                if (prev_trig) begin
                    n_fail++;
                    $display("FAIL trig_spacing: trigger high on consecutive cycles at t=%0t", $time);
                end
            end
            if (pkt_err) err_seen++;
            if ((x !== prev_x) || (y !== prev_y)) begin
                n_checks++;
                if (!trigger) begin
                    n_fail++;
                    $display("FAIL xy_hold: x/y changed to %0d/%0d without trigger", x, y);
                end
            end
        end
        prev_trig = trigger;
        prev_x    = x;
        prev_y    = y;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_time++;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [47:0] p, input int n, input int gap, output int chk_cyc);
        chk_cyc = 0;
        for (int i = 0; i < n; i++) begin
            chk_cyc = model_time;
            send_byte(p[47-8*i -: 8]);
            if (i < n - 1) idle(gap);
        end
    endtask

    task automatic note_error();
        exp_errp++;
        if (exp_errs < 255) exp_errs++;
    endtask

    task automatic note_accept(input logic [10:0] ax, input logic [9:0] ay, input int cyc);
        exp_trig++;
        exp_x    = ax;
        exp_y    = ay;
        have_acc = 1'b1;
        last_acc = cyc;
    endtask

    // Packet-level rules: header bits, XOR checksum, screen range, repeat window.
    task automatic model_packet(input logic [47:0] p, input int chk_cyc);
        logic [7:0] xh, xl, yh, yl, ck;
        int xv, yv;
        bit dup;
        xh = p[39:32]; xl = p[31:24]; yh = p[23:16]; yl = p[15:8]; ck = p[7:0];
        xv = int'(xh) * 256 + int'(xl);
        yv = int'(yh) * 256 + int'(yl);
        if (xh > 8'd7 || yh > 8'd3 || ck != (xh ^ xl ^ yh ^ yl) || xv >= H || yv >= V) begin
            note_error();
        end else begin
            dup = have_acc && (xv == int'(exp_x)) && (yv == int'(exp_y))
                  && ((chk_cyc - last_acc - 1) < DUP);
            if (!dup) note_accept(11'(xv), 10'(yv), chk_cyc);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_trig"}, trig_seen, exp_trig);
        chk({tag, "_err"}, err_seen, exp_errp);
        chk({tag, "_x"}, 32'(x), 32'(exp_x));
        chk({tag, "_y"}, 32'(y), 32'(exp_y));
        chk({tag, "_errcnt"}, 32'(err_count), exp_errs);
    endtask

    task automatic run_model_pkt(input string tag, input logic [47:0] p, input int n, input int gap);
        int c;
        send_pkt(p, n, gap, c);
        model_packet(p, c);
        idle(2);
        check_all(tag);
    endtask

    function automatic logic [47:0] mk(input logic [7:0] xh, input logic [7:0] xl,
                                       input logic [7:0] yh, input logic [7:0] yl);
        return {8'hA5, xh, xl, yh, yl, xh ^ xl ^ yh ^ yl};
    endfunction

    typedef struct {
        logic [47:0] pkt;
        int          pre;
        bit          trig;
        bit          err;
        logic [10:0] ex;
        logic [9:0]  ey;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int c, sel, kind, gap, pre, n;
        logic [10:0] rx_x;
        logic [9:0]  rx_y;
        logic [47:0] p;
        logic [10:0] xs[4];
        logic [9:0]  ys[4];

        vecs[0]  = '{48'hA5012C00C8E5, 0,    1'b1, 1'b0, 11'd300,  10'd200};
        vecs[1]  = '{48'hA5012C00C8E5, 1000, 1'b0, 1'b0, 11'd300,  10'd200};
        vecs[2]  = '{48'hA5012C00C8E5, 2010, 1'b1, 1'b0, 11'd300,  10'd200};
        vecs[3]  = '{48'hA5012C00C8E4, 0,    1'b0, 1'b1, 11'd300,  10'd200};
        vecs[4]  = '{48'hA50400000004, 0,    1'b0, 1'b1, 11'd300,  10'd200};
        vecs[5]  = '{48'hA503FF02FF01, 0,    1'b1, 1'b0, 11'd1023, 10'd767};
        vecs[6]  = '{48'hA50000030003, 0,    1'b0, 1'b1, 11'd1023, 10'd767};
        vecs[7]  = '{48'hA500A50010B5, 0,    1'b1, 1'b0, 11'd165,  10'd16};
        vecs[8]  = '{48'hA50800000008, 0,    1'b0, 1'b1, 11'd165,  10'd16};
        vecs[9]  = '{48'hA50000040004, 0,    1'b0, 1'b1, 11'd165,  10'd16};
        vecs[10] = '{48'hA500A50010B5, 0,    1'b0, 1'b0, 11'd165,  10'd16};
        vecs[11] = '{48'hA507FF02FF05, 0,    1'b0, 1'b1, 11'd165,  10'd16};

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = '0;
        idle(3);
        chk("rst_trigger", 32'(trigger), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_pkt_err", 32'(pkt_err), 0);
        chk("rst_err_count", 32'(err_count), 0);
        #2 reset_n = 1'b1;
        idle(2);

        for (int i = 0; i < 12; i++) begin
            idle(vecs[i].pre);
            send_pkt(vecs[i].pkt, 6, 0, c);
            if (vecs[i].trig) note_accept(vecs[i].ex, vecs[i].ey, c);
            if (vecs[i].err) note_error();
            idle(2);
            check_all($sformatf("vec%0d", i));
        end

        // Noise while hunting is ignored silently.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        idle(2);
        check_all("hunt_noise");

        // Packet stalls after XL: the gap timer must fire and return to HUNT.
        send_pkt(48'hA5012C000000, 3, 0, c);
        idle(TIMEOUT + 5);
        note_error();
        check_all("timeout");
        run_model_pkt("after_timeout", 48'hA5012C00C8E5, 6, 0);

        // Slow but in-time bytes.
        run_model_pkt("slow_pkt", mk(8'h00, 8'h05, 8'h00, 8'h07), 6, TIMEOUT - 2);

        xs[0] = 11'd0;   xs[1] = 11'd300; xs[2] = 11'd1023; xs[3] = 11'd512;
        ys[0] = 10'd0;   ys[1] = 10'd200; ys[2] = 10'd767;  ys[3] = 10'd383;
        for (int i = 0; i < 200; i++) begin
            sel  = int'($urandom % 16);
            rx_x = xs[sel % 4];
            rx_y = ys[sel / 4];
            kind = int'($urandom % 8);
            gap  = int'($urandom % 3);
            pre  = ($urandom % 20 == 0) ? int'($urandom_range(1500, 2500)) : int'($urandom % 4);
            n    = 6;
            if (kind == 1) rx_x = 11'($urandom_range(1024, 2047));
            if (kind == 2) rx_y = 10'($urandom_range(768, 1023));
            p = mk({5'd0, rx_x[10:8]}, rx_x[7:0], {6'd0, rx_y[9:8]}, rx_y[7:0]);
            if (kind == 0) p[7:0] = p[7:0] ^ 8'($urandom_range(1, 255));
            if (kind == 3) begin
                p[39:32] = 8'($urandom_range(8, 255));
                n = 2;
            end
            if (kind == 4) begin
                p[23:16] = 8'($urandom_range(4, 255));
                n = 4;
            end
            idle(pre);
            send_pkt(p, n, gap, c);
            model_packet(p, c);
            idle(2);
            if (i % 20 == 19) check_all($sformatf("rand%0d", i));
        end
        check_all("rand_end");

        for (int i = 0; i < 300; i++) begin
            send_pkt(48'hA5012C00C8E4, 6, 0, c);
            model_packet(48'hA5012C00C8E4, c);
        end
        idle(2);
        check_all("saturate");
        chk("saturate_255", 32'(err_count), 255);

        // Reset mid-packet: outputs clear without waiting for a clock edge.
        run_model_pkt("pre_reset", mk(8'h02, 8'h10, 8'h01, 8'h20), 6, 0);
        send_byte(8'hA5); send_byte(8'h01);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_x", 32'(x), 0);
        chk("async_rst_y", 32'(y), 0);
        chk("async_rst_err_count", 32'(err_count), 0);
        chk("async_rst_trigger", 32'(trigger), 0);
        chk("async_rst_pkt_err", 32'(pkt_err), 0);
        exp_x = '0; exp_y = '0; exp_errs = 0; have_acc = 1'b0;
        idle(2);
        #2 reset_n = 1'b1;
        idle(1);
        // Tail of the interrupted packet falls into HUNT and is ignored.
        send_byte(8'h2C); send_byte(8'h00); send_byte(8'hC8); send_byte(8'hE5);
        idle(2);
        check_all("post_reset_tail");
        run_model_pkt("post_reset_zero", mk(8'h00, 8'h00, 8'h00, 8'h00), 6, 0);
        chk("post_reset_accept", 32'(exp_trig - trig_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
